// File: rtl/cpu_core_mc.sv
// rtl/cpu_core_mc.sv - multi-cycle FETCH/EXEC/MEM/WB core with register file and data port
// Optional feature: define CPU_CORE_MC_MUL_EN to enable ALU op 8 (MUL).
module cpu_core_mc #(
  parameter int DATA_W  = 16,
  parameter int REG_CNT = 16,
  parameter int PC_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              instr_req,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic [PC_W-1:0]   pc,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              halted
);

  localparam int RI_W = (REG_CNT > 1) ? $clog2(REG_CNT) : 1;
  localparam int SA_W = $clog2(DATA_W);

  typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  state_t            state;
  logic [31:0]       ir;
  logic [DATA_W-1:0] regs [REG_CNT];
  logic [DATA_W-1:0] wb_data;
  logic              wb_en;
  logic [RI_W-1:0]   wb_rd;
  logic              br_taken;
  logic [PC_W-1:0]   br_target;

  logic              is_alu;
  logic [4:0]        op;
  logic [2:0]        cls;
  logic [RI_W-1:0]   rd_i, rs1_i, rs2_i;
  logic [DATA_W-1:0] rs1_v, rs2_v, rd_v, imm_d;
  logic [31:0]       imm32;
  logic [PC_W-1:0]   imm_pc;
  logic [DATA_W-1:0] alu_res;
  logic              alu_wr;
  logic              unused_ir;

  assign is_alu = ir[31];
  assign op     = ir[30:26];
  assign cls    = ir[30:28];
  assign rd_i   = ir[21 +: RI_W];
  assign rs1_i  = ir[16 +: RI_W];
  assign rs2_i  = ir[11 +: RI_W];
  // Register 0 is never written, so reading it always yields zero.
  assign rs1_v  = regs[rs1_i];
  assign rs2_v  = regs[rs2_i];
  assign rd_v   = regs[rd_i];
  assign imm32  = {16'h0000, ir[15:0]};
  assign imm_d  = imm32[DATA_W-1:0];
  assign imm_pc = imm32[PC_W-1:0];
  assign unused_ir = ^{ir[25:21], ir[20:16], ir[15:11], imm32};

  always_comb begin
    alu_res = '0;
    alu_wr  = 1'b1;
    case (op)
      5'd0: alu_res = rs1_v + rs2_v;
      5'd1: alu_res = rs1_v - rs2_v;
      5'd2: alu_res = rs1_v & rs2_v;
      5'd3: alu_res = rs1_v | rs2_v;
      5'd4: alu_res = rs1_v ^ rs2_v;
      5'd5: alu_res = rs1_v << rs2_v[SA_W-1:0];
      5'd6: alu_res = rs1_v >> rs2_v[SA_W-1:0];
      5'd7: alu_res = {{(DATA_W-1){1'b0}}, (rs1_v < rs2_v)};
`ifdef CPU_CORE_MC_MUL_EN
      5'd8: alu_res = rs1_v * rs2_v;
`endif
      default: alu_wr = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      pc        <= '0;
      ir        <= '0;
      instr_req <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      halted    <= 1'b0;
      wb_data   <= '0;
      wb_en     <= 1'b0;
      wb_rd     <= '0;
      br_taken  <= 1'b0;
      br_target <= '0;
      for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (instr_valid) begin
            ir        <= instr;
            instr_req <= 1'b0;
            state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          wb_en     <= 1'b0;
          wb_rd     <= rd_i;
          br_taken  <= 1'b0;
          br_target <= imm_pc;
          state     <= S_WB;
          if (is_alu) begin
            wb_en   <= alu_wr;
            wb_data <= alu_res;
          end else begin
            case (cls)
              3'b000: begin
                wb_en   <= 1'b1;
                wb_data <= imm_d;
              end
              3'b001: begin
                wb_en    <= 1'b1;
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= rs1_v + imm_d;
                state    <= S_MEM;
              end
              3'b010: begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= rs1_v + imm_d;
                mem_wdata <= rd_v;
                state     <= S_MEM;
              end
              3'b011: br_taken <= (rs1_v == '0);
              3'b100: br_taken <= 1'b1;
              3'b111: begin
                halted <= 1'b1;
                state  <= S_HALT;
              end
              default: ;
            endcase
          end
        end
        S_MEM: begin
          // Request and its address/data stay put until the memory acknowledges.
          if (mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!mem_we) wb_data <= mem_rdata;
            state <= S_WB;
          end
        end
        S_WB: begin
          if (wb_en && (wb_rd != '0)) regs[wb_rd] <= wb_data;
          pc        <= br_taken ? br_target : pc + PC_W'(1);
          instr_req <= 1'b1;
          state     <= S_FETCH;
        end
        S_HALT: ;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_core_mc.sv
// tb/tb_cpu_core_mc.sv - randomized bench for cpu_core_mc against an instruction-level model
module tb_cpu_core_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_req, instr_valid;
  logic [31:0] instr;
  logic [15:0] pc;
  logic        mem_req, mem_we, mem_ready, halted;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  logic        instr_req8, instr_valid8, mem_req8, halted8;
  logic [31:0] instr8;
  logic [15:0] pc8;
  logic        unused8_we;
  logic [7:0]  unused8_addr, unused8_wdata;

  cpu_core_mc dut (
    .clk(clk), .rst(rst), .instr_req(instr_req), .instr_valid(instr_valid), .instr(instr),
    .pc(pc), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .halted(halted)
  );

  cpu_core_mc #(.DATA_W(8)) dut8 (
    .clk(clk), .rst(rst), .instr_req(instr_req8), .instr_valid(instr_valid8), .instr(instr8),
    .pc(pc8), .mem_req(mem_req8), .mem_we(unused8_we), .mem_addr(unused8_addr),
    .mem_wdata(unused8_wdata), .mem_rdata(8'h00), .mem_ready(1'b0), .halted(halted8)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // instruction-level reference state
  logic [15:0] m_regs [16];
  logic [15:0] m_pc;
  logic [15:0] m_mem [logic [15:0]];
  int          m_cycles;
  logic        m_is_mem, m_we;
  logic [15:0] m_addr, m_wdata;

  // external data memory driven by DUT stores
  logic [15:0] dmem [logic [15:0]];

  int          last_cycles;
  logic        saw_mem, cap_we, stable_ok;
  logic [15:0] cap_addr, cap_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  function automatic logic [31:0] enc_alu(input int op, input int rd, input int rs1, input int rs2);
    logic [31:0] w;
    w = '0;
    w[31] = 1'b1;
    w[30:26] = op[4:0];
    w[25:21] = rd[4:0];
    w[20:16] = rs1[4:0];
    w[15:11] = rs2[4:0];
    return w;
  endfunction

  function automatic logic [31:0] enc_i(input int cls, input int rd, input int rs1, input logic [15:0] imm);
    logic [31:0] w;
    w = '0;
    w[30:28] = cls[2:0];
    w[25:21] = rd[4:0];
    w[20:16] = rs1[4:0];
    w[15:0]  = imm;
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
    m_pc = 16'h0;
  endtask

  task automatic model_exec(input logic [31:0] w, input int delay);
    int rd, rs1, rs2;
    logic [15:0] a, b, res, imm, nxt;
    logic wr;
    rd  = int'(w[25:21]) % 16;
    rs1 = int'(w[20:16]) % 16;
    rs2 = int'(w[15:11]) % 16;
    a = m_regs[rs1];
    b = m_regs[rs2];
    imm = w[15:0];
    res = 16'h0;
    wr = 1'b0;
    nxt = m_pc + 16'd1;
    m_cycles = 3;
    m_is_mem = 1'b0;
    if (w[31]) begin
      wr = 1'b1;
      case (int'(w[30:26]))
        0: res = a + b;
        1: res = a - b;
        2: res = a & b;
        3: res = a | b;
        4: res = a ^ b;
        5: res = a << b[3:0];
        6: res = a >> b[3:0];
        7: res = (a < b) ? 16'd1 : 16'd0;
`ifdef CPU_CORE_MC_MUL_EN
        8: res = a * b;
`endif
        default: wr = 1'b0;
      endcase
    end else begin
      case (int'(w[30:28]))
        0: begin res = imm; wr = 1'b1; end
        1: begin
          m_is_mem = 1'b1; m_we = 1'b0; m_addr = a + imm;
          res = m_mem.exists(m_addr) ? m_mem[m_addr] : init_val(m_addr);
          wr = 1'b1;
          m_cycles = 4 + delay;
        end
        2: begin
          m_is_mem = 1'b1; m_we = 1'b1; m_addr = a + imm; m_wdata = m_regs[rd];
          m_mem[m_addr] = m_wdata;
          m_cycles = 4 + delay;
        end
        3: if (a == 16'h0) nxt = imm;
        4: nxt = imm;
        default: ;
      endcase
    end
    if (wr && rd != 0) m_regs[rd] = res;
    m_pc = nxt;
  endtask

  // Feeds one instruction and services any data access with the given wait.
  task automatic exec_instr(input logic [31:0] w, input int delay);
    int wait_cnt;
    for (int k = 0; k < 50 && !instr_req; k++) step();
    if (!instr_req) begin
      check("fetch_wait_timeout", 32'd0, 32'd1);
      return;
    end
    instr = w;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    last_cycles = 1;
    saw_mem = 1'b0;
    stable_ok = 1'b1;
    wait_cnt = 0;
    for (int k = 0; k < 50; k++) begin
      if (instr_req || halted) break;
      instr = $urandom;
      instr_valid = 1'($urandom);
      if (mem_req) begin
        if (!saw_mem) begin
          saw_mem = 1'b1;
          cap_addr = mem_addr; cap_we = mem_we; cap_wdata = mem_wdata;
        end else if (mem_addr !== cap_addr || mem_we !== cap_we || (cap_we && mem_wdata !== cap_wdata)) begin
          stable_ok = 1'b0;
        end
        mem_rdata = dmem.exists(mem_addr) ? dmem[mem_addr] : init_val(mem_addr);
        if (wait_cnt == delay) begin
          mem_ready = 1'b1;
          if (mem_we) dmem[mem_addr] = mem_wdata;
        end else begin
          mem_ready = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_ready = 1'($urandom);
      end
      step();
      mem_ready = 1'b0;
      last_cycles++;
    end
    instr_valid = 1'b0;
    mem_ready = 1'b0;
    if (!(instr_req || halted)) check("instr_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run(input string tag, input logic [31:0] w, input int delay);
    int rd;
    rd = int'(w[25:21]) % 16;
    model_exec(w, delay);
    exec_instr(w, delay);
    check({tag, "_pc"}, 32'(pc), 32'(m_pc));
    check({tag, "_cycles"}, 32'(last_cycles), 32'(m_cycles));
    check({tag, "_rd"}, 32'(dut.regs[rd]), 32'(m_regs[rd]));
    check({tag, "_memreq"}, 32'(saw_mem), 32'(m_is_mem));
    if (m_is_mem && saw_mem) begin
      check({tag, "_addr"}, 32'(cap_addr), 32'(m_addr));
      check({tag, "_we"}, 32'(cap_we), 32'(m_we));
      check({tag, "_stable"}, 32'(stable_ok), 32'd1);
      if (m_we) check({tag, "_wdata"}, 32'(cap_wdata), 32'(m_wdata));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    instr_valid = 1'b0;
    instr_valid8 = 1'b0;
    mem_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic exec8(input logic [31:0] w);
    for (int k = 0; k < 20 && !instr_req8; k++) step();
    if (!instr_req8) check("fetch8_timeout", 32'd0, 32'd1);
    instr8 = w;
    instr_valid8 = 1'b1;
    step();
    instr_valid8 = 1'b0;
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int total;
    logic [31:0] w;
    logic ok;
    instr = '0; instr_valid = 1'b0; instr8 = '0; instr_valid8 = 1'b0;
    mem_ready = 1'b0; mem_rdata = '0;
    do_reset();

    check("rst_pc", 32'(pc), 32'h0);
    check("rst_instr_req", 32'(instr_req), 32'h1);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);

    run("li_r1", enc_i(0, 1, 0, 16'd5), 0);
    total = last_cycles;
    run("li_r2", enc_i(0, 2, 0, 16'd3), 0);
    total += last_cycles;
    run("add_r3", enc_alu(0, 3, 1, 2), 0);
    total += last_cycles;
    check("add_r3_val", 32'(dut.regs[3]), 32'd8);
    check("seq_pc", 32'(pc), 32'd3);
    check("seq_total_cycles", 32'(total), 32'd9);

    run("st_r3", enc_i(2, 3, 0, 16'h0010), 0);
    check("st_addr_lit", 32'(cap_addr), 32'h10);
    check("st_we_lit", 32'(cap_we), 32'h1);
    run("ld_r4", enc_i(1, 4, 0, 16'h0010), 2);
    check("ld_addr_lit", 32'(cap_addr), 32'h10);
    check("ld_we_lit", 32'(cap_we), 32'h0);
    check("ld_r4_val", 32'(dut.regs[4]), 32'd8);
    check("ld_cycles_lit", 32'(last_cycles), 32'd6);

    run("beqz_taken", enc_i(3, 0, 0, 16'h0020), 0);
    check("beqz_taken_pc", 32'(pc), 32'h20);
    run("beqz_not", enc_i(3, 0, 1, 16'h0040), 0);
    check("beqz_not_pc", 32'(pc), 32'h21);

    run("li6", enc_i(0, 1, 0, 16'd6), 0);
    run("li7", enc_i(0, 2, 0, 16'd7), 0);
    run("li77", enc_i(0, 3, 0, 16'h0077), 0);
    run("op8", enc_alu(8, 3, 1, 2), 0);
`ifdef CPU_CORE_MC_MUL_EN
    check("op8_r3", 32'(dut.regs[3]), 32'd42);
`else
    check("op8_r3", 32'(dut.regs[3]), 32'h77);
`endif
    run("wr_r0", enc_i(0, 0, 0, 16'h1234), 0);
    check("r0_zero", 32'(dut.regs[0]), 32'h0);

    run("jmp_top", enc_i(4, 0, 0, 16'hFFFF), 0);
    check("jmp_top_pc", 32'(pc), 32'hFFFF);
    run("nop_wrap", enc_i(5, 0, 0, 16'h0000), 0);
    check("pc_wrap", 32'(pc), 32'h0);

    exec8(enc_i(0, 1, 0, 16'h01FF));
    exec8(enc_i(0, 2, 0, 16'h0001));
    exec8(enc_alu(0, 3, 1, 2));
    check("w8_li_trunc", 32'(dut8.regs[1]), 32'hFF);
    check("w8_add_wrap", 32'(dut8.regs[3]), 32'h00);
    check("w8_pc", 32'(pc8), 32'd3);
    check("w8_idle", 32'({mem_req8, halted8}), 32'h0);

    for (int n = 0; n < 300; n++) begin
      case ($urandom % 10)
        0, 1, 2, 3: begin
          w = enc_alu(int'($urandom % 10), int'($urandom % 32), int'($urandom % 32), int'($urandom % 32));
          w[10:0] = 11'($urandom);
        end
        4: w = enc_i(0, int'($urandom % 32), 0, ($urandom % 2 == 0) ? 16'($urandom % 64) : 16'($urandom));
        5: w = enc_i(1, int'($urandom % 32), int'($urandom % 32), 16'($urandom % 64));
        6: w = enc_i(2, int'($urandom % 32), int'($urandom % 32), 16'($urandom % 64));
        7: w = enc_i(3, int'($urandom % 32), int'($urandom % 32), 16'($urandom));
        8: w = enc_i(($urandom % 4 == 0) ? 4 : 0, int'($urandom % 32), 0, 16'($urandom));
        default: w = enc_i(5 + int'($urandom % 2), int'($urandom % 32), int'($urandom % 32), 16'($urandom));
      endcase
      if (!w[31]) w[27:26] = 2'($urandom);
      run($sformatf("rnd%0d", n), w, int'($urandom % 4));
    end

    for (int k = 0; k < 50 && !instr_req; k++) step();
    instr = enc_i(7, 0, 0, 16'h0);
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    step();
    check("halt_flag", 32'(halted), 32'h1);
    ok = 1'b1;
    for (int k = 0; k < 6; k++) begin
      instr = $urandom;
      instr_valid = 1'b1;
      mem_ready = 1'b1;
      step();
      if (!halted || instr_req || mem_req) ok = 1'b0;
    end
    instr_valid = 1'b0;
    mem_ready = 1'b0;
    check("halt_hold", 32'(ok), 32'h1);
    check("halt_pc", 32'(pc), 32'(m_pc));

    do_reset();
    check("halt_rst_halted", 32'(halted), 32'h0);
    check("halt_rst_req", 32'(instr_req), 32'h1);
    run("pre_li", enc_i(0, 1, 0, 16'h0009), 0);
    run("pre_jmp", enc_i(4, 0, 0, 16'h0055), 0);
    for (int k = 0; k < 50 && !instr_req; k++) step();
    instr = enc_i(1, 4, 0, 16'h0010);
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    check("midmem_req", 32'(mem_req), 32'h1);
    rst = 1'b1;
    step();
    check("midmem_rst_req", 32'(mem_req), 32'h0);
    check("midmem_rst_pc", 32'(pc), 32'h0);
    check("midmem_rst_ireq", 32'(instr_req), 32'h1);
    rst = 1'b0;
    model_reset();
    check("midmem_rst_r1", 32'(dut.regs[1]), 32'h0);
    run("post_rst_li", enc_i(0, 5, 0, 16'h00A5), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
